bus_rr_arbiter: RTL

- Round-robin arbiter and data/control multiplexer for the shared system bus: up to 8 masters request the bus; exactly one is granted at a time.
- Drives the granted master's data and control words onto the common bus that all slaves (e.g. the audio copper) observe.
- Sits between master bus_out/ctrl_out ports and the shared bus/ctrl nets.
- Non-preemptive; an optional hold-time watchdog forces release.

---
 rtl/bus_rr_arbiter.sv | 124 ++++++++++++
 1 files changed

// File: rtl/bus_rr_arbiter.sv
// Round-robin bus arbiter and data/control mux for up to 8 masters; ack/grant_id registered, bus mux combinational.
// Non-preemptive grants; optional hold watchdog enabled by macro BUS_ARB_TIMEOUT_EN (default build: disabled).
module bus_rr_arbiter #(
  parameter int NUM_MASTERS = 8,
  parameter int IDX_WIDTH   = 3,
  parameter int BUS_WIDTH   = 32,
  parameter int CTRL_WIDTH  = 8,
  parameter int HOLD_MAX    = 256
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_MASTERS-1:0]            req,
  output logic [NUM_MASTERS-1:0]            ack,
  input  logic [NUM_MASTERS*BUS_WIDTH-1:0]  bus_in,
  input  logic [NUM_MASTERS*CTRL_WIDTH-1:0] ctrl_in,
  output logic [BUS_WIDTH-1:0]              bus_out,
  output logic [CTRL_WIDTH-1:0]             ctrl_out,
  output logic [IDX_WIDTH-1:0]              grant_id,
  output logic                              busy,
  output logic                              timeout
);

  if (NUM_MASTERS < 2 || NUM_MASTERS > 8 || (1 << IDX_WIDTH) < NUM_MASTERS) begin : g_bad_masters
    $error("bus_rr_arbiter: illegal NUM_MASTERS/IDX_WIDTH");
  end
  if (HOLD_MAX < 2 || HOLD_MAX > 65535) begin : g_bad_hold
    $error("bus_rr_arbiter: illegal HOLD_MAX");
  end

  typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;

  state_t               state;
  logic [IDX_WIDTH-1:0] last_owner;
  logic [IDX_WIDTH-1:0] sel;
  logic                 sel_vld;
  logic                 owner_req;

  // Scan starts just past the last owner so it becomes lowest priority.
  always_comb begin
    sel     = '0;
    sel_vld = 1'b0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      int idx;
      idx = (int'(last_owner) + k) % NUM_MASTERS;
      if (!sel_vld && req[idx]) begin
        sel     = IDX_WIDTH'(idx);
        sel_vld = 1'b1;
      end
    end
  end

  always_comb begin
    bus_out   = '0;
    ctrl_out  = '0;
    owner_req = 1'b0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (grant_id == IDX_WIDTH'(i)) begin
        owner_req = req[i];
        if (state == GRANT) begin
          bus_out  = bus_in[i*BUS_WIDTH +: BUS_WIDTH];
          ctrl_out = ctrl_in[i*CTRL_WIDTH +: CTRL_WIDTH];
        end
      end
    end
  end

`ifdef BUS_ARB_TIMEOUT_EN
  logic [15:0] hold_cnt;
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ack        <= '0;
      grant_id   <= '0;
      busy       <= 1'b0;
      last_owner <= IDX_WIDTH'(NUM_MASTERS - 1);
`ifdef BUS_ARB_TIMEOUT_EN
      hold_cnt   <= '0;
      timeout    <= 1'b0;
`endif
    end else begin
`ifdef BUS_ARB_TIMEOUT_EN
      timeout <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (sel_vld) begin
            state    <= GRANT;
            ack      <= NUM_MASTERS'(1) << sel;
            grant_id <= sel;
            busy     <= 1'b1;
`ifdef BUS_ARB_TIMEOUT_EN
            hold_cnt <= '0;
`endif
          end
        end
        GRANT: begin
          if (!owner_req) begin
            state      <= TURN;
            ack        <= '0;
            busy       <= 1'b0;
            last_owner <= grant_id;
          end
`ifdef BUS_ARB_TIMEOUT_EN
          else if (hold_cnt == 16'(HOLD_MAX - 1)) begin
            state      <= TURN;
            ack        <= '0;
            busy       <= 1'b0;
            last_owner <= grant_id;
            timeout    <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + 16'd1;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
